writeback_regfile: RTL and testbench

WRITEBACK_REGFILE -- requirements
Module: writeback_regfile

---
 rtl/writeback_regfile_pkg.sv | 11 +
 rtl/writeback_regfile_wb_mux.sv | 15 +
 rtl/writeback_regfile.sv | 75 +++++++
 tb/tb_writeback_regfile.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/writeback_regfile_pkg.sv
// Shared constants for the writeback / register-file slice.
// Optional feature macro used by writeback_regfile: WB_BYPASS_EN.
package writeback_regfile_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/writeback_regfile_wb_mux.sv
// Writeback source select: load data or ALU result, purely combinational.
module wb_mux #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              MemtoReg_i,
    input  logic [DATA_W-1:0] ALUResult_i,
    input  logic [DATA_W-1:0] MemData_i,
    output logic [DATA_W-1:0] WBData_o
);

    always_comb begin
        WBData_o = MemtoReg_i ? MemData_i : ALUResult_i;
    end

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage plus architectural register file with commit counter.
// Define WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module writeback_regfile
    import writeback_regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = writeback_regfile_pkg::DATA_W,
    parameter int unsigned NUM_REGS = writeback_regfile_pkg::NUM_REGS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  MemtoReg_i,
    input  logic                  RegWrite_i,
    input  logic [DATA_W-1:0]     ALUResult_i,
    input  logic [DATA_W-1:0]     MemData_i,
    input  logic [REG_ADDR_W-1:0] RegAddr_i,
    input  logic [REG_ADDR_W-1:0] RS1addr_i,
    input  logic [REG_ADDR_W-1:0] RS2addr_i,
    output logic [DATA_W-1:0]     RS1data_o,
    output logic [DATA_W-1:0]     RS2data_o,
    output logic [DATA_W-1:0]     WBData_o,
    output logic [31:0]           WrCount_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [31:0]       wr_count_q;
    logic [31:0]       wr_count_d;
    logic [DATA_W-1:0] wb_data;
    logic              commit;

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .MemtoReg_i  (MemtoReg_i),
        .ALUResult_i (ALUResult_i),
        .MemData_i   (MemData_i),
        .WBData_o    (wb_data)
    );

    assign WBData_o  = wb_data;
    assign WrCount_o = wr_count_q;

    always_comb begin
        commit     = RegWrite_i && (RegAddr_i != ZERO_REG);
        wr_count_d = commit ? (wr_count_q + 32'd1) : wr_count_q;
    end

    // Reset wins over a coincident write, so neither the data nor the count lands.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else begin
            if (commit) begin
                regs_q[RegAddr_i] <= wb_data;
            end
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        RS1data_o = (RS1addr_i == ZERO_REG) ? '0 : regs_q[RS1addr_i];
        RS2data_o = (RS2addr_i == ZERO_REG) ? '0 : regs_q[RS2addr_i];
`ifdef WB_BYPASS_EN
        if (commit && !rst_i && (RS1addr_i == RegAddr_i)) begin
            RS1data_o = wb_data;
        end
        if (commit && !rst_i && (RS2addr_i == RegAddr_i)) begin
            RS2data_o = wb_data;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized self-checking bench for writeback_regfile against an array-based model.
module tb_writeback_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        m2r;
    logic        we;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  waddr;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] wbd;
    logic [31:0] wcnt;

    logic [31:0] mregs [32];
    logic [31:0] mcnt;
    int unsigned checks = 0;
    int unsigned errors = 0;

    writeback_regfile #(
        .DATA_W   (32),
        .NUM_REGS (32)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .MemtoReg_i  (m2r),
        .RegWrite_i  (we),
        .ALUResult_i (alu),
        .MemData_i   (mem),
        .RegAddr_i   (waddr),
        .RS1addr_i   (ra1),
        .RS2addr_i   (ra2),
        .RS1data_o   (rd1),
        .RS2data_o   (rd2),
        .WBData_o    (wbd),
        .WrCount_o   (wcnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_wb();
        return m2r ? mem : alu;
    endfunction

    // Architectural view of a read in the current cycle.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (!rst && we && waddr != 5'd0 && a == waddr) return exp_wb();
`endif
        return mregs[a];
    endfunction

    task automatic drive(input logic r, input logic w, input logic s, input logic [31:0] a,
                         input logic [31:0] m, input logic [4:0] wa, input logic [4:0] r1,
                         input logic [4:0] r2);
        rst = r; we = w; m2r = s; alu = a; mem = m; waddr = wa; ra1 = r1; ra2 = r2;
    endtask

    // Check combinational outputs, then advance one edge and update the model.
    task automatic cycle();
        #1;
        check("wbdata", wbd, exp_wb());
        check("rs1", rd1, exp_read(ra1));
        check("rs2", rd2, exp_read(ra2));
        check("wrcount", wcnt, mcnt);
        @(posedge clk);
        if (rst) begin
            foreach (mregs[i]) mregs[i] = 32'd0;
            mcnt = 32'd0;
        end else if (we && waddr != 5'd0) begin
            mregs[waddr] = exp_wb();
            mcnt = mcnt + 32'd1;
        end
        @(negedge clk);
    endtask

    initial begin
        foreach (mregs[i]) mregs[i] = 32'd0;
        mcnt = 32'd0;
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        @(posedge clk);
        @(negedge clk);

        // Random preload, then a single reset edge clears everything.
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        for (int i = 1; i < 32; i++) begin
            drive(1'b0, 1'b1, $urandom_range(0, 1), $urandom, $urandom, i[4:0], $urandom, $urandom);
            cycle();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
        cycle();
        for (int i = 0; i < 32; i += 2) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, '0, i[4:0], 5'(i + 1));
            #1;
            check("rst_clear1", rd1, 32'd0);
            check("rst_clear2", rd2, 32'd0);
            check("rst_count", wcnt, 32'd0);
            cycle();
        end

        // ALU result into r5.
        drive(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h0, 5'd5, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd5, 5'd0);
        #1;
        check("r5_alu", rd1, 32'h1234_5678);
        check("r5_count", wcnt, 32'd1);
        cycle();

        // Write to r0 discarded and not counted.
        drive(1'b0, 1'b1, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0, 5'd0);
        #1;
        check("wb_mem", wbd, 32'hDEAD_BEEF);
        cycle();
        #1;
        check("r0_zero", rd2, 32'd0);
        check("r0_count", wcnt, 32'd1);

        // Same-cycle read of a register being written.
        drive(1'b0, 1'b1, 1'b0, 32'h1, 32'h0, 5'd7, 5'd0, 5'd0);
        cycle();
        drive(1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, 32'h0, 5'd7, 5'd7, 5'd7);
        #1;
`ifdef WB_BYPASS_EN
        check("r7_same1", rd1, 32'hA5A5_A5A5);
        check("r7_same2", rd2, 32'hA5A5_A5A5);
`else
        check("r7_same1", rd1, 32'h1);
        check("r7_same2", rd2, 32'h1);
`endif
        cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd7, 5'd7);
        #1;
        check("r7_next1", rd1, 32'hA5A5_A5A5);
        check("r7_next2", rd2, 32'hA5A5_A5A5);
        cycle();

        // Reset coincident with a write to r3.
        drive(1'b1, 1'b1, 1'b0, 32'h55, 32'h0, 5'd3, 5'd3, 5'd3);
        cycle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 5'd3, 5'd3);
        #1;
        check("r3_rst", rd1, 32'd0);
        check("r3_count", wcnt, 32'd0);

        // Counter wrap: preset the count register, then commit one write.
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        mcnt = 32'hFFFF_FFFF;
        #1;
        check("cnt_preset", wcnt, 32'hFFFF_FFFF);
        drive(1'b0, 1'b1, 1'b0, 32'h9, 32'h0, 5'd9, 5'd0, 5'd0);
        cycle();
        #1;
        check("cnt_wrap", wcnt, 32'd0);

        // Random traffic with occasional resets and r0 writes.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom, $urandom, $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) ra1 = waddr;
            if ($urandom_range(0, 3) == 0) ra2 = ra1;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
